p405s_dcu_tagarray_nway: RTL and testbench

Parametrised N-way data-cache tag array. It generalises the fixed 2-way / 256-set DCU tag store with configurable ways, sets and tag width. Adds per-set round-robin victim selection, read-side tag compare with parity check, and a hardware invalidate sequencer for reset and flash invalidation. Sits between the DCU control FSM and the tag storage; storage is modelled behaviourally as a single-port register array inside the block.

---
 rtl/p405s_dcu_pkg.sv | 20 ++
 rtl/p405s_dcu_tagarray_nway_if.sv | 42 ++++
 rtl/p405s_dcu_tagarray_nway_victimrr.sv | 37 +++
 rtl/p405s_dcu_tagarray_nway.sv | 184 ++++++++++++++++++
 tb/tb_p405s_dcu_tagarray_nway.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/p405s_dcu_pkg.sv
// Shared definitions for the N-way DCU tag array.
//   dcuState_e : invalidate-sequencer / request FSM state encoding
//   tagParity  : even parity bit over a tag (callers zero-extend to PAR_MAX_W)
package p405s_dcu_pkg;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        IDLE  = 2'd1,
        FLASH = 2'd2
    } dcuState_e;

    // Widest tag the parity helper accepts; zero padding does not change parity.
    localparam int unsigned PAR_MAX_W = 64;

    // Even parity: stored bit makes the XOR of tag plus parity equal zero.
    function automatic logic tagParity(input logic [PAR_MAX_W-1:0] tag);
        return ^tag;
    endfunction

endpackage

// File: rtl/p405s_dcu_tagarray_nway_if.sv
// Request / read-result bundle of the N-way DCU tag array.
//   master : DCU control side (drives req_*, flash_inv)
//   slave  : tag array side (drives req_ready, rd_*, victim_way, init_busy)
interface p405s_dcu_tagarray_nway_if #(
    parameter int WAYS  = 2,
    parameter int IDX_W = 8,
    parameter int TAG_W = 21,
    parameter int WAY_W = $clog2(WAYS)
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_rnw;
    logic [IDX_W-1:0]        req_index;
    logic [TAG_W-1:0]        req_tag;
    logic [WAYS-1:0]         req_way_sel;
    logic                    req_use_victim;
    logic                    req_new_valid;
    logic                    req_new_attr;
    logic                    flash_inv;
    logic                    rd_valid;
    logic [WAYS*TAG_W-1:0]   rd_tag;
    logic [WAYS-1:0]         rd_vld;
    logic [WAYS-1:0]         rd_attr;
    logic [WAYS-1:0]         rd_hit;
    logic [WAYS-1:0]         rd_par_err;
    logic [WAY_W-1:0]        victim_way;
    logic                    init_busy;

    modport master (
        output req_valid, req_rnw, req_index, req_tag, req_way_sel,
               req_use_victim, req_new_valid, req_new_attr, flash_inv,
        input  req_ready, rd_valid, rd_tag, rd_vld, rd_attr, rd_hit,
               rd_par_err, victim_way, init_busy
    );

    modport slave (
        input  req_valid, req_rnw, req_index, req_tag, req_way_sel,
               req_use_victim, req_new_valid, req_new_attr, flash_inv,
        output req_ready, rd_valid, rd_tag, rd_vld, rd_attr, rd_hit,
               rd_par_err, victim_way, init_busy
    );
endinterface

// File: rtl/p405s_dcu_tagarray_nway_victimrr.sv
// Per-set round-robin victim pointer array.
//   rdIdx/rdPtr   : combinational pointer read
//   advEn/advIdx  : advance pointer of a set by one (natural wrap, WAYS is 2^n)
//   clrEn/clrIdx  : clear pointer of a set (takes priority over advance)
module p405s_dcu_victimRR #(
    parameter int WAYS  = 2,
    parameter int IDX_W = 8
)(
    input  logic                       CB,
    input  logic                       rst_n,
    input  logic [IDX_W-1:0]           rdIdx,
    output logic [$clog2(WAYS)-1:0]    rdPtr,
    input  logic                       advEn,
    input  logic [IDX_W-1:0]           advIdx,
    input  logic                       clrEn,
    input  logic [IDX_W-1:0]           clrIdx
);
    localparam int SETS  = 2**IDX_W;
    localparam int WAY_W = $clog2(WAYS);

    logic [WAY_W-1:0] ptrR [SETS];

    assign rdPtr = ptrR[rdIdx];

    // Pointer storage: async clear, sequencer clear, victim-write advance.
    always_ff @(posedge CB or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                ptrR[s] <= '0;
            end
        end else if (clrEn) begin
            ptrR[clrIdx] <= '0;
        end else if (advEn) begin
            ptrR[advIdx] <= ptrR[advIdx] + WAY_W'(1);
        end
    end
endmodule

// File: rtl/p405s_dcu_tagarray_nway.sv
// N-way data-cache tag array with round-robin victim selection, parity-checked
// tag compare and a hardware invalidate walker (reset INIT and flash FLASH).
//   CB    : clock          rst_n : async active-low reset
//   bus   : request / read-result bundle (slave side)
module p405s_dcu_tagarray_nway
    import p405s_dcu_pkg::*;
#(
    parameter int WAYS  = 2,
    parameter int IDX_W = 8,
    parameter int TAG_W = 21,
    parameter int WAY_W = $clog2(WAYS)
)(
    input  logic                          CB,
    input  logic                          rst_n,
    p405s_dcu_tagarray_nway_if.slave      bus
);
    localparam int SETS = 2**IDX_W;

    dcuState_e               stateR, nextStateS;
    logic [IDX_W-1:0]        invCntR;
    logic                    walkS;
    logic                    acceptS, rdAccS, wrAccS;
    logic [WAY_W-1:0]        curPtrS;
    logic [WAYS-1:0]         wayMaskS;

    // Storage: tag/parity/attr are plain RAM-like arrays; valid bits are flops
    // so the walker can clear a whole set per cycle.
    logic [TAG_W-1:0]           tagMem  [SETS][WAYS];
    logic [SETS-1:0][WAYS-1:0]  parMem;
    logic [WAYS-1:0]            attrMem [SETS];
    logic [WAYS-1:0]            vldR    [SETS];

    logic [WAYS*TAG_W-1:0]   rdTagS, rdTagR;
    logic [WAYS-1:0]         rdVldS, rdAttrS, rdHitS, rdPerrS;
    logic [WAYS-1:0]         rdVldR, rdAttrR, rdHitR, rdPerrR;
    logic                    rdValidR;
    logic [WAY_W-1:0]        victimR;

    assign bus.req_ready = (stateR == IDLE) & ~bus.flash_inv;
    assign bus.init_busy = (stateR != IDLE);
    assign acceptS       = bus.req_valid & bus.req_ready;
    assign rdAccS        = acceptS & bus.req_rnw;
    assign wrAccS        = acceptS & ~bus.req_rnw;

    // Victim writes target the set's current pointer; otherwise the explicit
    // (possibly multi-hot or empty) way select is used.
    assign wayMaskS = bus.req_use_victim ? (WAYS'(1'b1) << curPtrS) : bus.req_way_sel;

    p405s_dcu_victimRR #(.WAYS(WAYS), .IDX_W(IDX_W)) uVictim (
        .CB     (CB),
        .rst_n  (rst_n),
        .rdIdx  (bus.req_index),
        .rdPtr  (curPtrS),
        .advEn  (wrAccS & bus.req_use_victim),
        .advIdx (bus.req_index),
        .clrEn  (walkS),
        .clrIdx (invCntR)
    );

    // State register.
    always_ff @(posedge CB or negedge rst_n) begin
        if (!rst_n) begin
            stateR <= INIT;
        end else begin
            stateR <= nextStateS;
        end
    end

    // Next state: walks end after the last set; flash only starts from IDLE.
    always_comb begin
        nextStateS = stateR;
        walkS      = 1'b0;
        case (stateR)
            INIT, FLASH: begin
                walkS = 1'b1;
                if (invCntR == {IDX_W{1'b1}}) begin
                    nextStateS = IDLE;
                end else begin
                    nextStateS = stateR;
                end
            end
            IDLE: begin
                if (bus.flash_inv) begin
                    nextStateS = FLASH;
                end else begin
                    nextStateS = IDLE;
                end
            end
            default: begin
                nextStateS = INIT;
                walkS      = 1'b0;
            end
        endcase
    end

    // Walk counter; wraps to zero at the end of each walk.
    always_ff @(posedge CB or negedge rst_n) begin
        if (!rst_n) begin
            invCntR <= '0;
        end else if (walkS) begin
            invCntR <= invCntR + IDX_W'(1);
        end
    end

    // Valid bits: cleared by reset and by the walker, set/cleared by writes.
    always_ff @(posedge CB or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                vldR[s] <= '0;
            end
        end else if (walkS) begin
            vldR[invCntR] <= '0;
        end else if (wrAccS) begin
            for (int w = 0; w < WAYS; w++) begin
                if (wayMaskS[w]) begin
                    vldR[bus.req_index][w] <= bus.req_new_valid;
                end
            end
        end
    end

    // Tag, parity and attribute storage (not reset).
    always_ff @(posedge CB) begin
        if (wrAccS) begin
            for (int w = 0; w < WAYS; w++) begin
                if (wayMaskS[w]) begin
                    tagMem[bus.req_index][w]  <= bus.req_tag;
                    parMem[bus.req_index][w]  <= tagParity(PAR_MAX_W'(bus.req_tag));
                    attrMem[bus.req_index][w] <= bus.req_new_attr;
                end
            end
        end
    end

    // Read path: tag compare and parity check; errors only flagged on valid ways.
    always_comb begin
        rdTagS  = '0;
        rdVldS  = '0;
        rdAttrS = '0;
        rdHitS  = '0;
        rdPerrS = '0;
        for (int w = 0; w < WAYS; w++) begin
            rdTagS[(WAYS-1-w)*TAG_W +: TAG_W] = tagMem[bus.req_index][w];
            rdVldS[w]  = vldR[bus.req_index][w];
            rdAttrS[w] = attrMem[bus.req_index][w];
            rdPerrS[w] = vldR[bus.req_index][w] &
                         (tagParity(PAR_MAX_W'(tagMem[bus.req_index][w])) != parMem[bus.req_index][w]);
            rdHitS[w]  = vldR[bus.req_index][w] &
                         (tagMem[bus.req_index][w] == bus.req_tag) &
                         (tagParity(PAR_MAX_W'(tagMem[bus.req_index][w])) == parMem[bus.req_index][w]);
        end
    end

    // Read result registers; held until the next accepted read.
    always_ff @(posedge CB or negedge rst_n) begin
        if (!rst_n) begin
            rdValidR <= 1'b0;
            rdTagR   <= '0;
            rdVldR   <= '0;
            rdAttrR  <= '0;
            rdHitR   <= '0;
            rdPerrR  <= '0;
            victimR  <= '0;
        end else begin
            rdValidR <= rdAccS;
            if (rdAccS) begin
                rdTagR  <= rdTagS;
                rdVldR  <= rdVldS;
                rdAttrR <= rdAttrS;
                rdHitR  <= rdHitS;
                rdPerrR <= rdPerrS;
                victimR <= curPtrS;
            end
        end
    end

    assign bus.rd_valid   = rdValidR;
    assign bus.rd_tag     = rdTagR;
    assign bus.rd_vld     = rdVldR;
    assign bus.rd_attr    = rdAttrR;
    assign bus.rd_hit     = rdHitR;
    assign bus.rd_par_err = rdPerrR;
    assign bus.victim_way = victimR;
endmodule

// File: tb/tb_p405s_dcu_tagarray_nway.sv
// Scoreboard bench: reads push expected results, per-DUT monitors pop and
// compare whenever rd_valid is seen. DUT A: WAYS=2/IDX_W=8, DUT B: WAYS=4/IDX_W=3.
module tb_p405s_dcu_tagarray_nway;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    p405s_dcu_tagarray_nway_if #(.WAYS(2), .IDX_W(8), .TAG_W(21)) ifA ();
    p405s_dcu_tagarray_nway_if #(.WAYS(4), .IDX_W(3), .TAG_W(21)) ifB ();

    p405s_dcu_tagarray_nway #(.WAYS(2), .IDX_W(8), .TAG_W(21)) dut_a (
        .CB(clk), .rst_n(rst_n), .bus(ifA));
    p405s_dcu_tagarray_nway #(.WAYS(4), .IDX_W(3), .TAG_W(21)) dut_b (
        .CB(clk), .rst_n(rst_n), .bus(ifB));

    typedef struct {
        logic [83:0] tag;
        logic [3:0]  vld;
        logic [3:0]  attr;
        logic [3:0]  hit;
        logic [3:0]  perr;
        logic [1:0]  vic;
        logic        chkData;
    } exp_t;

    exp_t qA[$];
    exp_t qB[$];
    int nPass  = 0;
    int nTotal = 0;
    logic [255:0][1:0] parForce;

    task automatic chk(input string name, input logic [83:0] act, input logic [83:0] exp);
        nTotal++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic exp_t mkExp(input logic [83:0] tag, input logic [3:0] vld,
                                   input logic [3:0] attr, input logic [3:0] hit,
                                   input logic [3:0] perr, input logic [1:0] vic,
                                   input logic cd);
        exp_t e;
        e.tag = tag; e.vld = vld; e.attr = attr; e.hit = hit;
        e.perr = perr; e.vic = vic; e.chkData = cd;
        return e;
    endfunction

    // Monitor for DUT A.
    always @(negedge clk) begin : monA
        exp_t e;
        if (ifA.rd_valid === 1'b1) begin
            if (qA.size() == 0) begin
                chk("a_rd_valid_unexpected", 84'(ifA.rd_valid), 84'd0);
            end else begin
                e = qA.pop_front();
                chk("a_rd_vld",     84'(ifA.rd_vld),     84'(e.vld));
                chk("a_rd_hit",     84'(ifA.rd_hit),     84'(e.hit));
                chk("a_rd_par_err", 84'(ifA.rd_par_err), 84'(e.perr));
                chk("a_victim_way", 84'(ifA.victim_way), 84'(e.vic));
                if (e.chkData) begin
                    chk("a_rd_tag",  84'(ifA.rd_tag),  e.tag);
                    chk("a_rd_attr", 84'(ifA.rd_attr), 84'(e.attr));
                end
            end
        end
    end

    // Monitor for DUT B.
    always @(negedge clk) begin : monB
        exp_t e;
        if (ifB.rd_valid === 1'b1) begin
            if (qB.size() == 0) begin
                chk("b_rd_valid_unexpected", 84'(ifB.rd_valid), 84'd0);
            end else begin
                e = qB.pop_front();
                chk("b_rd_vld",     84'(ifB.rd_vld),     84'(e.vld));
                chk("b_rd_hit",     84'(ifB.rd_hit),     84'(e.hit));
                chk("b_rd_par_err", 84'(ifB.rd_par_err), 84'(e.perr));
                chk("b_victim_way", 84'(ifB.victim_way), 84'(e.vic));
                if (e.chkData) begin
                    chk("b_rd_tag",  84'(ifB.rd_tag),  e.tag);
                    chk("b_rd_attr", 84'(ifB.rd_attr), 84'(e.attr));
                end
            end
        end
    end

    task automatic reqA(input logic rnw, input logic [7:0] idx, input logic [20:0] tag,
                        input logic [1:0] sel, input logic vic, input logic nv, input logic at);
        ifA.req_valid = 1'b1; ifA.req_rnw = rnw; ifA.req_index = idx; ifA.req_tag = tag;
        ifA.req_way_sel = sel; ifA.req_use_victim = vic; ifA.req_new_valid = nv;
        ifA.req_new_attr = at;
        #1;
        chk("a_req_ready", 84'(ifA.req_ready), 84'd1);
        @(posedge clk); #1;
        ifA.req_valid = 1'b0;
    endtask

    task automatic readA(input logic [7:0] idx, input logic [20:0] tag, input exp_t e);
        qA.push_back(e);
        reqA(1'b1, idx, tag, 2'b00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic reqB(input logic rnw, input logic [2:0] idx, input logic [20:0] tag,
                        input logic [3:0] sel, input logic vic, input logic nv, input logic at);
        ifB.req_valid = 1'b1; ifB.req_rnw = rnw; ifB.req_index = idx; ifB.req_tag = tag;
        ifB.req_way_sel = sel; ifB.req_use_victim = vic; ifB.req_new_valid = nv;
        ifB.req_new_attr = at;
        #1;
        chk("b_req_ready", 84'(ifB.req_ready), 84'd1);
        @(posedge clk); #1;
        ifB.req_valid = 1'b0;
    endtask

    task automatic readB(input logic [2:0] idx, input logic [20:0] tag, input exp_t e);
        qB.push_back(e);
        reqB(1'b1, idx, tag, 4'b0000, 1'b0, 1'b0, 1'b0);
    endtask

    // Count cycles of init_busy on DUT A (bounded); optionally pulse flash_inv mid-walk.
    task automatic countBusyA(input string name, input int pulseAt);
        int n;
        logic readySeen;
        n = 0;
        readySeen = 1'b0;
        while (ifA.init_busy === 1'b1 && n < 400) begin
            ifA.flash_inv = (n == pulseAt);
            #1;
            if (ifA.req_ready !== 1'b0) readySeen = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        ifA.flash_inv = 1'b0;
        chk(name, 84'(n), 84'd256);
        chk("a_ready_while_busy", 84'(readySeen), 84'd0);
    endtask

    initial begin
        ifA.req_valid = 1'b0; ifA.req_rnw = 1'b0; ifA.req_index = '0; ifA.req_tag = '0;
        ifA.req_way_sel = '0; ifA.req_use_victim = 1'b0; ifA.req_new_valid = 1'b0;
        ifA.req_new_attr = 1'b0; ifA.flash_inv = 1'b0;
        ifB.req_valid = 1'b0; ifB.req_rnw = 1'b0; ifB.req_index = '0; ifB.req_tag = '0;
        ifB.req_way_sel = '0; ifB.req_use_victim = 1'b0; ifB.req_new_valid = 1'b0;
        ifB.req_new_attr = 1'b0; ifB.flash_inv = 1'b0;

        // Reset values.
        #1 rst_n = 1'b0;
        #2;
        chk("rst_req_ready",  84'(ifA.req_ready),  84'd0);
        chk("rst_rd_valid",   84'(ifA.rd_valid),   84'd0);
        chk("rst_rd_tag",     84'(ifA.rd_tag),     84'd0);
        chk("rst_rd_vld",     84'(ifA.rd_vld),     84'd0);
        chk("rst_rd_attr",    84'(ifA.rd_attr),    84'd0);
        chk("rst_rd_hit",     84'(ifA.rd_hit),     84'd0);
        chk("rst_rd_par_err", 84'(ifA.rd_par_err), 84'd0);
        chk("rst_victim_way", 84'(ifA.victim_way), 84'd0);
        chk("rst_init_busy",  84'(ifA.init_busy),  84'd1);
        chk("rst_b_init_busy", 84'(ifB.init_busy), 84'd1);

        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        countBusyA("a_init_walk_len", -1);

        // Freshly invalidated array.
        readA(8'h3F, 21'h0, mkExp(84'd0, 4'b00, 4'b00, 4'b00, 4'b00, 2'd0, 1'b0));

        // Two victim writes to set 5 fill both ways and wrap the pointer.
        reqA(1'b0, 8'h05, 21'h1ABCD, 2'b00, 1'b1, 1'b1, 1'b1);
        reqA(1'b0, 8'h05, 21'h1ABCD, 2'b00, 1'b1, 1'b1, 1'b0);
        readA(8'h05, 21'h1ABCD, mkExp(84'({21'h1ABCD, 21'h1ABCD}), 4'b11, 4'b01, 4'b11, 4'b00, 2'd0, 1'b1));
        readA(8'h05, 21'h00001, mkExp(84'({21'h1ABCD, 21'h1ABCD}), 4'b11, 4'b01, 4'b00, 4'b00, 2'd0, 1'b1));

        // Multi-hot write to set 9, then corrupt way 1 parity.
        reqA(1'b0, 8'h09, 21'h0F0F0, 2'b11, 1'b0, 1'b1, 1'b1);
        parForce = dut_a.parMem;
        parForce[9][1] = ~parForce[9][1];
        force dut_a.parMem = parForce;
        readA(8'h09, 21'h0F0F0, mkExp(84'({21'h0F0F0, 21'h0F0F0}), 4'b11, 4'b11, 4'b01, 4'b10, 2'd0, 1'b1));
        @(posedge clk); #1;
        release dut_a.parMem;

        // Empty way select writes nothing.
        reqA(1'b0, 8'h0C, 21'h12345, 2'b00, 1'b0, 1'b1, 1'b1);
        readA(8'h0C, 21'h12345, mkExp(84'd0, 4'b00, 4'b00, 4'b00, 4'b00, 2'd0, 1'b0));

        // Advance set 30's pointer so the flash clear is observable.
        reqA(1'b0, 8'h1E, 21'h00777, 2'b00, 1'b1, 1'b1, 1'b0);
        readA(8'h1E, 21'h00777, mkExp(84'd0, 4'b01, 4'b00, 4'b01, 4'b00, 2'd1, 1'b0));
        @(posedge clk); #1;

        // Flash with a same-cycle read: read must not be accepted.
        ifA.flash_inv = 1'b1; ifA.req_valid = 1'b1; ifA.req_rnw = 1'b1; ifA.req_index = 8'h05;
        #1;
        chk("a_ready_during_flash_req", 84'(ifA.req_ready), 84'd0);
        @(posedge clk); #1;
        ifA.flash_inv = 1'b0; ifA.req_valid = 1'b0;
        countBusyA("a_flash_walk_len", 50);
        readA(8'h1E, 21'h00777, mkExp(84'd0, 4'b00, 4'b00, 4'b00, 4'b00, 2'd0, 1'b0));
        readA(8'h05, 21'h1ABCD, mkExp(84'd0, 4'b00, 4'b00, 4'b00, 4'b00, 2'd0, 1'b0));

        // Non-zero read result, then reset 100 cycles into a flash walk.
        reqA(1'b0, 8'h07, 21'h0AAAA, 2'b00, 1'b1, 1'b1, 1'b0);
        readA(8'h07, 21'h0AAAA, mkExp(84'd0, 4'b01, 4'b00, 4'b01, 4'b00, 2'd1, 1'b0));
        @(posedge clk); #1;
        ifA.flash_inv = 1'b1;
        @(posedge clk); #1;
        ifA.flash_inv = 1'b0;
        repeat (100) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_rd_vld",     84'(ifA.rd_vld),     84'd0);
        chk("midrst_rd_hit",     84'(ifA.rd_hit),     84'd0);
        chk("midrst_victim_way", 84'(ifA.victim_way), 84'd0);
        chk("midrst_rd_tag",     84'(ifA.rd_tag),     84'd0);
        chk("midrst_req_ready",  84'(ifA.req_ready),  84'd0);
        chk("midrst_init_busy",  84'(ifA.init_busy),  84'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        countBusyA("a_reinit_walk_len", -1);
        readA(8'h07, 21'h0AAAA, mkExp(84'd0, 4'b00, 4'b00, 4'b00, 4'b00, 2'd0, 1'b0));

        // DUT B: four victim fills then a fifth that overwrites way 0.
        chk("b_idle", 84'(ifB.init_busy), 84'd0);
        reqB(1'b0, 3'd2, 21'h00011, 4'b0000, 1'b1, 1'b1, 1'b1);
        reqB(1'b0, 3'd2, 21'h00022, 4'b0000, 1'b1, 1'b1, 1'b1);
        reqB(1'b0, 3'd2, 21'h00033, 4'b0000, 1'b1, 1'b1, 1'b1);
        reqB(1'b0, 3'd2, 21'h00044, 4'b0000, 1'b1, 1'b1, 1'b1);
        reqB(1'b0, 3'd2, 21'h1FFFF, 4'b0000, 1'b1, 1'b1, 1'b1);
        readB(3'd2, 21'h1FFFF, mkExp({21'h1FFFF, 21'h00022, 21'h00033, 21'h00044},
                                     4'b1111, 4'b1111, 4'b0001, 4'b0000, 2'd1, 1'b1));
        readB(3'd2, 21'h00033, mkExp({21'h1FFFF, 21'h00022, 21'h00033, 21'h00044},
                                     4'b1111, 4'b1111, 4'b0100, 4'b0000, 2'd1, 1'b1));

        repeat (4) @(posedge clk);
        #1;
        chk("a_queue_drained", 84'(qA.size()), 84'd0);
        chk("b_queue_drained", 84'(qB.size()), 84'd0);
        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end

endmodule
